// File: rtl/dmem_port_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_port_arbiter
//
// Purpose:
//   Shares port A of the single-port data block RAM between the CPU load/store
//   path and a DMA/loader engine (for example a UART bootloader filling
//   memory). A registered ownership FSM selects the port mux. While the DMA
//   owns the port, a pending CPU request is held off with Stall. DMA bursts
//   are bounded to MAX_BURST beats while the CPU is waiting, so the CPU is
//   never starved.
//
// Ports:
//   CLK          system clock, rising edge
//   reset        asynchronous, active-high reset
//   cpu_req      CPU wants the port this cycle (decoded load/store)
//   cpu_we       CPU byte write-enables (0 = read)
//   cpu_addr     CPU word address
//   cpu_din      CPU store data
//   dma_req      DMA wants a beat
//   dma_we       DMA byte write-enables (0 = read)
//   dma_addr     DMA word address
//   dma_din      DMA write data
//   dma_gnt      DMA beat accepted this cycle (same-cycle grant)
//   dma_rvalid   RAM read data for the DMA is valid this cycle
//   mem_en       RAM port enable
//   mem_wea      RAM byte write-enables
//   mem_addr     RAM word address
//   mem_din      RAM write data
//   Stall        freeze the CPU pipeline
//   stall_cycles performance counter of cycles with Stall = 1
//
// Optional feature:
//   ARB_PERF_CNT_EN  when defined, stall_cycles is a saturating 16-bit count
//                    of stall cycles; when undefined it is tied to zero and
//                    no counter is built.
// -----------------------------------------------------------------------------
module dmem_port_arbiter #(
    parameter int ADDR_W    = 12,
    parameter int DATA_W    = 32,
    parameter int MAX_BURST = 8     // legal range 2..255
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic [3:0]        cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_din,
    input  logic              dma_req,
    input  logic [3:0]        dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_din,
    output logic              dma_gnt,
    output logic              dma_rvalid,
    output logic              mem_en,
    output logic [3:0]        mem_wea,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    output logic              Stall,
    output logic [15:0]       stall_cycles
);

    typedef enum logic [1:0] {
        CPU_OWN  = 2'd0,
        DMA_OWN  = 2'd1,
        CPU_SLOT = 2'd2
    } state_t;

    // Last beat index of a bounded burst; the counter saturates here.
    localparam logic [7:0] BURST_LAST = 8'(MAX_BURST - 1);

    state_t     state_reg;
    logic [7:0] burst_cnt_reg;
    logic       dma_rvalid_reg;
    logic       dma_sel;

    // The port mux is driven straight from the registered state so the
    // grant and the stall are visible in the same cycle as the request.
    // CPU_SLOT behaves exactly like CPU_OWN on the outputs.
    assign dma_sel = (state_reg == DMA_OWN);

    always_comb begin
        if (dma_sel) begin
            mem_en   = dma_req;
            mem_wea  = dma_req ? dma_we : 4'h0;
            mem_addr = dma_addr;
            mem_din  = dma_din;
            dma_gnt  = dma_req;
            Stall    = cpu_req;
        end else begin
            mem_en   = cpu_req;
            mem_wea  = cpu_req ? cpu_we : 4'h0;
            mem_addr = cpu_addr;
            mem_din  = cpu_din;
            dma_gnt  = 1'b0;
            Stall    = 1'b0;
        end
    end

    assign dma_rvalid = dma_rvalid_reg;

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state_reg      <= CPU_OWN;
            burst_cnt_reg  <= 8'd0;
            dma_rvalid_reg <= 1'b0;
        end else begin
            // RAM read latency is one cycle, independent of who owns the
            // port in the following cycle.
            dma_rvalid_reg <= dma_gnt && (dma_we == 4'h0);

            case (state_reg)
                CPU_OWN: begin
                    // The CPU keeps this cycle even if it is also requesting;
                    // the DMA gets its first beat next cycle.
                    if (dma_req) begin
                        state_reg     <= DMA_OWN;
                        burst_cnt_reg <= 8'd0;
                    end
                end
                DMA_OWN: begin
                    if (!dma_req) begin
                        state_reg <= CPU_OWN;
                    end else begin
                        // The beat is granted this cycle either way; only a
                        // waiting CPU can end a saturated burst.
                        if (cpu_req && (burst_cnt_reg == BURST_LAST)) begin
                            state_reg <= CPU_SLOT;
                        end
                        if (burst_cnt_reg != BURST_LAST) begin
                            burst_cnt_reg <= burst_cnt_reg + 8'd1;
                        end
                    end
                end
                CPU_SLOT: begin
                    if (dma_req) begin
                        state_reg     <= DMA_OWN;
                        burst_cnt_reg <= 8'd0;
                    end else begin
                        state_reg <= CPU_OWN;
                    end
                end
                default: begin
                    state_reg <= CPU_OWN;
                end
            endcase
        end
    end

`ifdef ARB_PERF_CNT_EN
    logic [15:0] stall_cycles_reg;

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            stall_cycles_reg <= 16'h0000;
        end else if (Stall && (stall_cycles_reg != 16'hFFFF)) begin
            stall_cycles_reg <= stall_cycles_reg + 16'h0001;
        end
    end

    assign stall_cycles = stall_cycles_reg;
`else
    assign stall_cycles = 16'h0000;
`endif

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_port_arbiter
//
// Self-checking bench for dmem_port_arbiter. A behavioural model tracks who
// owns the port as "owner" plus the number of beats granted in the current
// burst, and predicts every output each cycle. Directed steps cover the
// reset state, simultaneous requests, the burst bound, read latency, an
// asynchronous reset mid-burst and the stall counter; a random phase follows.
// -----------------------------------------------------------------------------
module tb_dmem_port_arbiter;

    localparam int ADDR_W    = 12;
    localparam int DATA_W    = 32;
    localparam int MAX_BURST = 8;

    logic              CLK;
    logic              reset;
    logic              cpu_req;
    logic [3:0]        cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_din;
    logic              dma_req;
    logic [3:0]        dma_we;
    logic [ADDR_W-1:0] dma_addr;
    logic [DATA_W-1:0] dma_din;
    logic              dma_gnt;
    logic              dma_rvalid;
    logic              mem_en;
    logic [3:0]        mem_wea;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_din;
    logic              Stall;
    logic [15:0]       stall_cycles;

    dmem_port_arbiter #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .MAX_BURST(MAX_BURST)
    ) dut (
        .CLK         (CLK),
        .reset       (reset),
        .cpu_req     (cpu_req),
        .cpu_we      (cpu_we),
        .cpu_addr    (cpu_addr),
        .cpu_din     (cpu_din),
        .dma_req     (dma_req),
        .dma_we      (dma_we),
        .dma_addr    (dma_addr),
        .dma_din     (dma_din),
        .dma_gnt     (dma_gnt),
        .dma_rvalid  (dma_rvalid),
        .mem_en      (mem_en),
        .mem_wea     (mem_wea),
        .mem_addr    (mem_addr),
        .mem_din     (mem_din),
        .Stall       (Stall),
        .stall_cycles(stall_cycles)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int checks   = 0;
    int failures = 0;
    int cycle_no = 0;

    // Behavioural model: who owns the port, beats granted so far in this
    // burst, whether a one-cycle CPU turn is owed, read-return flag, and
    // number of stall cycles seen.
    bit dma_owns;
    bit cpu_turn;
    int beats;
    bit rv_pending;
    int stall_seen;

    // Predicted outputs for the current cycle.
    logic              e_en;
    logic [3:0]        e_wea;
    logic [ADDR_W-1:0] e_addr;
    logic [DATA_W-1:0] e_din;
    logic              e_gnt;
    logic              e_stall;
    logic [15:0]       e_cnt;

    task automatic model_reset();
        dma_owns   = 1'b0;
        cpu_turn   = 1'b0;
        beats      = 0;
        rv_pending = 1'b0;
        stall_seen = 0;
    endtask

    task automatic predict();
        if (dma_owns) begin
            e_en    = dma_req;
            e_wea   = dma_req ? dma_we : 4'h0;
            e_addr  = dma_addr;
            e_din   = dma_din;
            e_gnt   = dma_req;
            e_stall = cpu_req;
        end else begin
            e_en    = cpu_req;
            e_wea   = cpu_req ? cpu_we : 4'h0;
            e_addr  = cpu_addr;
            e_din   = cpu_din;
            e_gnt   = 1'b0;
            e_stall = 1'b0;
        end
`ifdef ARB_PERF_CNT_EN
        e_cnt = (stall_seen > 65535) ? 16'hFFFF : 16'(stall_seen);
`else
        e_cnt = 16'h0000;
`endif
    endtask

    // Advance the model across one rising edge using the inputs of the
    // cycle just ended.
    task automatic model_edge();
        predict();
        rv_pending = e_gnt && (dma_we == 4'h0);
        if (e_stall) stall_seen++;
        if (dma_owns) begin
            if (!dma_req) begin
                dma_owns = 1'b0;
            end else begin
                beats++;
                // A waiting CPU is let in once the burst reaches the bound.
                if (cpu_req && beats >= MAX_BURST) begin
                    dma_owns = 1'b0;
                    cpu_turn = 1'b1;
                end
            end
        end else if (dma_req) begin
            // From CPU ownership or the CPU turn, a DMA request always
            // starts a fresh burst next cycle.
            dma_owns = 1'b1;
            cpu_turn = 1'b0;
            beats    = 0;
        end else begin
            cpu_turn = 1'b0;
        end
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cycle_no);
        end
    endtask

    task automatic check_all();
        predict();
        chk("mem_en",       64'(mem_en),       64'(e_en));
        chk("mem_wea",      64'(mem_wea),      64'(e_wea));
        chk("mem_addr",     64'(mem_addr),     64'(e_addr));
        chk("mem_din",      64'(mem_din),      64'(e_din));
        chk("dma_gnt",      64'(dma_gnt),      64'(e_gnt));
        chk("Stall",        64'(Stall),        64'(e_stall));
        chk("dma_rvalid",   64'(dma_rvalid),   64'(rv_pending));
        chk("stall_cycles", 64'(stall_cycles), 64'(e_cnt));
    endtask

    task automatic drive(input logic creq, input logic [3:0] cwe, input logic [ADDR_W-1:0] caddr,
                         input logic dreq, input logic [3:0] dwe, input logic [ADDR_W-1:0] daddr);
        cpu_req  = creq;
        cpu_we   = cwe;
        cpu_addr = caddr;
        cpu_din  = $urandom;
        dma_req  = dreq;
        dma_we   = dwe;
        dma_addr = daddr;
        dma_din  = $urandom;
    endtask

    // Inputs are driven 2 time units after a rising edge; outputs are
    // checked 5 units later, well away from either edge.
    task automatic settle_and_check();
        #5;
        check_all();
        $display("cyc=%0d cpu_req=%0b dma_req=%0b mem_en=%0b mem_addr=%03h gnt=%0b rvalid=%0b stall=%0b cnt=%0d",
                 cycle_no, cpu_req, dma_req, mem_en, mem_addr, dma_gnt, dma_rvalid, Stall, stall_cycles);
    endtask

    task automatic finish_cycle();
        @(posedge CLK);
        model_edge();
        cycle_no++;
        #2;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        model_reset();
        @(posedge CLK);
        #2;
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        drive(1'b0, 4'h0, '0, 1'b0, 4'h0, '0);
        model_reset();
        #3;
        // Reset state while reset is held.
        check_all();
        chk("rst_stall", 64'(Stall), 64'd0);
        chk("rst_gnt",   64'(dma_gnt), 64'd0);
        chk("rst_cnt",   64'(stall_cycles), 64'd0);
        @(posedge CLK);
        #2;
        reset = 1'b0;

        // CPU alone: served in the same cycle.
        drive(1'b1, 4'hF, 12'h010, 1'b0, 4'h0, 12'h000);
        settle_and_check();
        chk("cpu_en",    64'(mem_en),   64'd1);
        chk("cpu_wea",   64'(mem_wea),  64'hF);
        chk("cpu_addr",  64'(mem_addr), 64'h010);
        chk("cpu_stall", 64'(Stall),    64'd0);
        finish_cycle();

        // Simultaneous requests, then hold both for 20 cycles: the CPU wins
        // the first cycle, then 8 DMA beats and one CPU slot repeat.
        begin
            int run = 0;
            for (int i = 0; i < 20; i++) begin
                drive(1'b1, 4'h0, 12'h004, 1'b1, 4'h3, 12'h100);
                settle_and_check();
                chk("burst_gnt",  64'(dma_gnt),  64'((i % 9) != 0));
                chk("burst_addr", 64'(mem_addr), ((i % 9) != 0) ? 64'h100 : 64'h004);
                chk("burst_stall", 64'(Stall),   64'((i % 9) != 0));
                run = dma_gnt ? run + 1 : 0;
                chk("burst_bound", 64'(run <= MAX_BURST), 64'd1);
                finish_cycle();
            end
        end

        // DMA read latency, then DMA write produces no read return.
        drive(1'b0, 4'h0, 12'h000, 1'b0, 4'h0, 12'h000);
        settle_and_check();
        finish_cycle();
        drive(1'b0, 4'h0, 12'h000, 1'b1, 4'h0, 12'h020);
        settle_and_check();
        finish_cycle();
        settle_and_check();
        chk("rd_gnt", 64'(dma_gnt), 64'd1);
        chk("rd_addr", 64'(mem_addr), 64'h020);
        finish_cycle();
        drive(1'b0, 4'h0, 12'h000, 1'b0, 4'h0, 12'h020);
        settle_and_check();
        chk("rd_rvalid_n1", 64'(dma_rvalid), 64'd1);
        finish_cycle();
        settle_and_check();
        chk("rd_rvalid_n2", 64'(dma_rvalid), 64'd0);
        finish_cycle();
        drive(1'b0, 4'h0, 12'h000, 1'b1, 4'hF, 12'h021);
        settle_and_check();
        finish_cycle();
        settle_and_check();
        chk("wr_gnt", 64'(dma_gnt), 64'd1);
        finish_cycle();
        drive(1'b0, 4'h0, 12'h000, 1'b0, 4'h0, 12'h000);
        settle_and_check();
        chk("wr_no_rvalid", 64'(dma_rvalid), 64'd0);
        finish_cycle();

        // Stall counter: 5 stalled beats from a fresh reset.
        apply_reset();
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 4'h0, 12'h008, 1'b1, 4'h0, 12'h200);
            settle_and_check();
            finish_cycle();
        end
        drive(1'b0, 4'h0, 12'h000, 1'b0, 4'h0, 12'h000);
        settle_and_check();
`ifdef ARB_PERF_CNT_EN
        chk("stall_cnt5", 64'(stall_cycles), 64'd5);
`else
        chk("stall_cnt0", 64'(stall_cycles), 64'd0);
`endif
        finish_cycle();

        // Asynchronous reset after 3 DMA read beats with the CPU waiting.
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 4'h0, 12'h030, 1'b1, 4'h0, 12'h300);
            settle_and_check();
            finish_cycle();
        end
        #3;
        chk("pre_rst_rvalid", 64'(dma_rvalid), 64'd1);
        reset = 1'b1;
        #1;
        model_reset();
        chk("arst_stall",  64'(Stall),      64'd0);
        chk("arst_gnt",    64'(dma_gnt),    64'd0);
        chk("arst_rvalid", 64'(dma_rvalid), 64'd0);
        chk("arst_addr",   64'(mem_addr),   64'h030);
        @(posedge CLK);
        #2;
        reset = 1'b0;
        // Back in CPU ownership with a fresh burst count: full 8-beat burst.
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 4'h0, 12'h030, 1'b1, 4'h0, 12'h300);
            settle_and_check();
            chk("post_rst_gnt", 64'(dma_gnt), 64'((i % 9) != 0));
            finish_cycle();
        end

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 12'($urandom),
                  1'($urandom_range(0, 3) != 0), 4'($urandom_range(0, 1) * $urandom_range(0, 15)),
                  12'($urandom));
            settle_and_check();
            finish_cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dmem_port_arbiter.md
Name: dmem_port_arbiter

Overview:
- Shares the single-port data block RAM (dma_port A: enable, byte write-enable, 12-bit word address, 32-bit write data) between two requesters: the CPU datapath's load/store path and a DMA/loader engine, such as a UART bootloader filling memory.
- Sequences port ownership with a registered FSM and drives Stall to the datapath while the DMA engine owns the port.
- Bounds DMA bursts so the CPU is never starved.
- Sits between the datapath/control unit and the RAM primitive.

Parameters:
- ADDR_W, 12, word-address width of the RAM port.
- DATA_W, 32, data width.
- MAX_BURST, 8, maximum consecutive DMA beats while a CPU request is pending. Legal range 2..255.

Ports:
- CLK  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- cpu_req  in  1  CPU wants the port this cycle (decoded load/store).
- cpu_we  in  4  CPU byte write-enables (0 = read).
- cpu_addr  in  ADDR_W  CPU word address.
- cpu_din  in  DATA_W  CPU store data.
- dma_req  in  1  DMA wants a beat.
- dma_we  in  4  DMA byte write-enables.
- dma_addr  in  ADDR_W  DMA word address.
- dma_din  in  DATA_W  DMA write data.
- dma_gnt  out  1  DMA beat accepted this cycle.
- dma_rvalid  out  1  RAM read data for the DMA is valid this cycle.
- mem_en  out  1  RAM port enable.
- mem_wea  out  4  RAM byte write-enables.
- mem_addr  out  ADDR_W  RAM address.
- mem_din  out  DATA_W  RAM write data.
- Stall  out  1  freeze the CPU pipeline.
- stall_cycles  out  16  performance counter (see Optional Feature).

Behaviour:
- Clocking and reset: CLK is the only clock. reset is asynchronous and active-high.
- Reset values:
  - state = CPU_OWN, burst_cnt = 0.
  - dma_gnt = 0, dma_rvalid = 0, Stall = 0, stall_cycles = 0.
  - mem_* follow the CPU mux, gated by cpu_req.
- States:
  - CPU_OWN: the port mux selects the CPU. mem_en = cpu_req, mem_wea = cpu_req ? cpu_we : 0. dma_gnt = 0, Stall = 0.
  - DMA_OWN: the port mux selects the DMA. mem_en = dma_req, mem_wea = dma_req ? dma_we : 0. dma_gnt = dma_req, Stall = cpu_req.
  - CPU_SLOT: same outputs as CPU_OWN. Lasts exactly one cycle.
- Transitions (registered, evaluated at the rising edge):
  - CPU_OWN -> DMA_OWN when dma_req = 1, with burst_cnt cleared to 0.
  - If cpu_req is high in that same cycle, the CPU access completes that cycle; the DMA gets its first beat in the next cycle. On a simultaneous request the CPU wins.
  - DMA_OWN -> CPU_OWN when dma_req = 0.
  - DMA_OWN -> CPU_SLOT when dma_req = 1, cpu_req = 1 and burst_cnt == MAX_BURST-1. The beat in that cycle is still granted.
  - DMA_OWN otherwise stays. burst_cnt increments on each granted beat and saturates at MAX_BURST-1.
  - CPU_SLOT -> DMA_OWN (burst_cnt cleared) if dma_req = 1, else -> CPU_OWN.
- Burst limit with no CPU request: if burst_cnt saturates while cpu_req = 0, the burst continues unbounded. The CPU_SLOT is inserted one cycle after cpu_req rises.
- Read latency is 1 cycle:
  - dma_rvalid is the registered value of (dma_gnt & (dma_we == 0)).
  - dma_rvalid is asserted in the cycle after the granted read, regardless of the state in that cycle.
  - CPU read data goes directly from RAM to the datapath with the same 1-cycle latency. The arbiter does not touch it.
- Stall is combinational from state and cpu_req, so the CPU's request and operands stay frozen until it is served.
- A DMA engine that deasserts dma_req mid-burst releases the port at the next edge. There is no beat loss because dma_gnt is same-cycle.
- Reset mid-burst: the state returns to CPU_OWN immediately, and a pending dma_rvalid is dropped (forced to 0).
- Address and data: passed through unchanged, with no width arithmetic. The mem_addr and mem_din mux uses the same select as mem_wea.

Optional Feature:
- Macro: ARB_PERF_CNT_EN.
- Defined: stall_cycles is a 16-bit counter that increments every cycle Stall = 1. It saturates at 16'hFFFF and clears on reset.
- Undefined: stall_cycles is tied to 16'h0000 and no counter logic is built.

Test Plan:
- After reset, cpu_req=1, cpu_we=4'hF, cpu_addr=12'h010, dma_req=0 -> same cycle mem_en=1, mem_wea=4'hF, mem_addr=12'h010, Stall=0, dma_gnt=0.
- Both cpu_req=1 and dma_req=1 in CPU_OWN, with cpu_addr=12'h004 and dma_addr=12'h100 -> cycle 0 mem_addr=12'h004; cycle 1 mem_addr=12'h100, dma_gnt=1, Stall=1.
- dma_req held high for 20 cycles with cpu_req held high, MAX_BURST=8 -> pattern of 8 DMA beats then 1 CPU slot (Stall=0, mem_addr=cpu_addr), repeating. No more than 8 consecutive dma_gnt.
- DMA read (dma_we=0) at 12'h020 granted in cycle N -> dma_rvalid=1 in cycle N+1 only. A DMA write at N produces no dma_rvalid at N+1.
- reset asserted asynchronously mid-burst after 3 beats -> Stall, dma_gnt and dma_rvalid go to 0 immediately. After release, the state is CPU_OWN and burst_cnt=0.
- With ARB_PERF_CNT_EN defined, force 5 stall cycles -> stall_cycles=5. Without the macro, stall_cycles=0.
